// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state type and iteration mode for the sequential ALU.
package alu_pkg;

   localparam logic [4:0] OP_AND  = 5'd0;
   localparam logic [4:0] OP_OR   = 5'd1;
   localparam logic [4:0] OP_NOT  = 5'd2;
   localparam logic [4:0] OP_NEG  = 5'd3;
   localparam logic [4:0] OP_ADD  = 5'd4;
   localparam logic [4:0] OP_SUB  = 5'd5;
   localparam logic [4:0] OP_MUL  = 5'd6;
   localparam logic [4:0] OP_DIV  = 5'd7;
   localparam logic [4:0] OP_SHR  = 5'd8;
   localparam logic [4:0] OP_SHRA = 5'd9;
   localparam logic [4:0] OP_SHL  = 5'd10;
   localparam logic [4:0] OP_ROR  = 5'd11;
   localparam logic [4:0] OP_ROL  = 5'd12;

   localparam int unsigned NUM_OPS = 13;

   typedef enum logic [1:0] {
      IDLE,
      MUL_IT,
      DIV_IT,
      FIN
   } state_t;

   typedef enum logic {
      MODE_MUL,
      MODE_DIV
   } iter_mode_t;

endpackage

// File: rtl/seq_alu_if.sv
// Operand/handshake/result bundle between the control unit and the ALU.
interface seq_alu_if #(
   parameter int unsigned WIDTH = 32
);
   logic               start;
   logic [4:0]         opcode;
   logic [WIDTH-1:0]   input_a;
   logic [WIDTH-1:0]   input_b;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] result;
   logic               overflow;
   logic               div_by_zero;
   logic               illegal_op;

   modport master (
      output start, opcode, input_a, input_b,
      input  busy, done, result, overflow, div_by_zero, illegal_op
   );

   modport slave (
      input  start, opcode, input_a, input_b,
      output busy, done, result, overflow, div_by_zero, illegal_op
   );
endinterface

// File: rtl/seq_alu_iter.sv
// Shared shift-register datapath: radix-2 Booth multiply or non-restoring
// divide on magnitudes, one step per cycle for WIDTH cycles after load.
module seq_alu_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  iter_mode_t       mode,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             last_step,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);
   localparam int unsigned SHW = $clog2(WIDTH);

   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic             qm1_q, qm1_d;
   logic [SHW:0]     cnt_q, cnt_d;
   iter_mode_t       mode_q, mode_d;

   logic [WIDTH:0]   m_ext;
   logic [WIDTH:0]   acc_sh;
   logic [WIDTH:0]   step_res;

   // Load operands or perform one Booth / non-restoring step
   always_comb begin
      acc_d    = acc_q;
      q_d      = q_q;
      m_d      = m_q;
      qm1_d    = qm1_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      m_ext    = (mode_q == MODE_MUL) ? {m_q[WIDTH-1], m_q} : {1'b0, m_q};
      acc_sh   = '0;
      step_res = acc_q;
      if (load) begin
         acc_d  = '0;
         q_d    = op_a;
         m_d    = op_b;
         qm1_d  = 1'b0;
         cnt_d  = (SHW+1)'(WIDTH);
         mode_d = mode;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - (SHW+1)'(1);
         if (mode_q == MODE_MUL) begin
            if (q_q[0] && !qm1_q)      step_res = acc_q - m_ext;
            else if (!q_q[0] && qm1_q) step_res = acc_q + m_ext;
            // arithmetic shift right of {acc, Q, q-1}
            acc_d = {step_res[WIDTH], step_res[WIDTH:1]};
            q_d   = {step_res[0], q_q[WIDTH-1:1]};
            qm1_d = q_q[0];
         end else begin
            acc_sh   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
            step_res = acc_q[WIDTH] ? (acc_sh + m_ext) : (acc_sh - m_ext);
            acc_d    = step_res;
            q_d      = {q_q[WIDTH-2:0], ~step_res[WIDTH]};
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q  <= '0;
         q_q    <= '0;
         m_q    <= '0;
         qm1_q  <= 1'b0;
         cnt_q  <= '0;
         mode_q <= MODE_MUL;
      end else begin
         acc_q  <= acc_d;
         q_q    <= q_d;
         m_q    <= m_d;
         qm1_q  <= qm1_d;
         cnt_q  <= cnt_d;
         mode_q <= mode_d;
      end
   end

   assign last_step = (cnt_q == (SHW+1)'(1));
   // divide: a negative final partial remainder gets one restoring add
   assign hi_o = (mode_q == MODE_DIV && acc_q[WIDTH]) ? (acc_q[WIDTH-1:0] + m_q)
                                                       : acc_q[WIDTH-1:0];
   assign lo_o = q_q;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative MUL/DIV
// through seq_alu_iter, start/busy/done handshake and status flags.
module seq_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic      clk,
   input  logic      reset_n,
   seq_alu_if.slave  bus
);
   localparam int unsigned SHW = $clog2(WIDTH);

   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               done_q, done_d;
   logic               ovf_q, ovf_d;
   logic               dbz_q, dbz_d;
   logic               ill_q, ill_d;
   logic               neg_quo_q, neg_quo_d;
   logic               neg_rem_q, neg_rem_d;

   logic [WIDTH-1:0]   a, b, lo_c;
   logic               ovf_c, ill_c;
   logic [SHW-1:0]     amt;
   logic [2*WIDTH-1:0] dbl;

   logic               iter_load, iter_last;
   iter_mode_t         iter_mode;
   logic [WIDTH-1:0]   iter_a, iter_b, iter_hi, iter_lo;
   logic [2*WIDTH-1:0] fin_result;

   seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (iter_load),
      .mode      (iter_mode),
      .op_a      (iter_a),
      .op_b      (iter_b),
      .last_step (iter_last),
      .hi_o      (iter_hi),
      .lo_o      (iter_lo)
   );

   // Single-cycle operations and their overflow / illegal flags
   always_comb begin
      a     = bus.input_a;
      b     = bus.input_b;
      amt   = b[SHW-1:0];
      lo_c  = '0;
      ovf_c = 1'b0;
      ill_c = 1'b0;
      dbl   = '0;
      case (bus.opcode)
         OP_AND:  lo_c = a & b;
         OP_OR:   lo_c = a | b;
         OP_NOT:  lo_c = ~a;
         OP_NEG: begin
            lo_c  = -a;
            ovf_c = a[WIDTH-1] & lo_c[WIDTH-1];
         end
         OP_ADD: begin
            lo_c  = a + b;
            ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (lo_c[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            lo_c  = a - b;
            ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (lo_c[WIDTH-1] != a[WIDTH-1]);
         end
         OP_MUL, OP_DIV: lo_c = '0;
         OP_SHR:  lo_c = a >> amt;
         OP_SHRA: lo_c = $signed(a) >>> amt;
         OP_SHL:  lo_c = a << amt;
         OP_ROR: begin
            dbl  = {a, a} >> amt;
            lo_c = dbl[WIDTH-1:0];
         end
         OP_ROL: begin
            dbl  = {a, a} << amt;
            lo_c = dbl[2*WIDTH-1:WIDTH];
         end
         default: ill_c = 1'b1;
      endcase
   end

   // DIV sign fix-up applied while in FIN
   always_comb begin
      fin_result[WIDTH-1:0]       = neg_quo_q ? -iter_lo : iter_lo;
      fin_result[2*WIDTH-1:WIDTH] = neg_rem_q ? -iter_hi : iter_hi;
   end

   // FSM next state, operation launch and result/flag capture
   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      done_d    = 1'b0;
      ovf_d     = ovf_q;
      dbz_d     = dbz_q;
      ill_d     = ill_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      iter_load = 1'b0;
      iter_mode = MODE_MUL;
      iter_a    = bus.input_a;
      iter_b    = bus.input_b;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.opcode == OP_MUL) begin
                  iter_load = 1'b1;
                  neg_quo_d = 1'b0;
                  neg_rem_d = 1'b0;
                  state_d   = MUL_IT;
               end else if (bus.opcode == OP_DIV && bus.input_b != '0) begin
                  iter_load = 1'b1;
                  iter_mode = MODE_DIV;
                  iter_a    = bus.input_a[WIDTH-1] ? -bus.input_a : bus.input_a;
                  iter_b    = bus.input_b[WIDTH-1] ? -bus.input_b : bus.input_b;
                  neg_quo_d = bus.input_a[WIDTH-1] ^ bus.input_b[WIDTH-1];
                  neg_rem_d = bus.input_a[WIDTH-1];
                  state_d   = DIV_IT;
               end else begin
                  done_d   = 1'b1;
                  ovf_d    = ovf_c;
                  ill_d    = ill_c;
                  dbz_d    = 1'b0;
                  result_d = {{WIDTH{1'b0}}, lo_c};
                  if (bus.opcode == OP_DIV) begin
                     result_d = {bus.input_a, {WIDTH{1'b1}}};
                     dbz_d    = 1'b1;
                  end
               end
            end
         end
         MUL_IT, DIV_IT: begin
            if (iter_last) state_d = FIN;
         end
         FIN: begin
            state_d  = IDLE;
            result_d = fin_result;
            ovf_d    = 1'b0;
            dbz_d    = 1'b0;
            ill_d    = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, result and flag registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         result_q  <= '0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         dbz_q     <= 1'b0;
         ill_q     <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
         dbz_q     <= dbz_d;
         ill_q     <= ill_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   // FIN presents the fixed-up iterative result directly so done and data align
   assign bus.busy        = (state_q == MUL_IT) || (state_q == DIV_IT);
   assign bus.done        = done_q || (state_q == FIN);
   assign bus.result      = (state_q == FIN) ? fin_result : result_q;
   assign bus.overflow    = (state_q == FIN) ? 1'b0 : ovf_q;
   assign bus.div_by_zero = (state_q == FIN) ? 1'b0 : dbz_q;
   assign bus.illegal_op  = (state_q == FIN) ? 1'b0 : ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32) against an arithmetic reference model.
module tb_seq_alu;
   import alu_pkg::*;

   localparam int unsigned W = 32;

   logic clk;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

   seq_alu_if #(.WIDTH(W)) bus ();

   seq_alu #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // Reference model computed from the operation definitions with 64-bit arithmetic
   function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [63:0] res, output logic ovf, output logic dbz,
                                 output logic ill, output int lat);
      longint sa, sb, s;
      logic [63:0] t;
      logic [31:0] r;
      int amt;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      amt = int'(b % 32);
      res = '0; ovf = 0; dbz = 0; ill = 0; lat = 1;
      case (op)
         5'd0: res = {32'h0, a & b};
         5'd1: res = {32'h0, a | b};
         5'd2: res = {32'h0, ~a};
         5'd3: begin s = -sa; t = s; res = {32'h0, t[31:0]}; ovf = (s > 64'sd2147483647); end
         5'd4: begin s = sa + sb; t = s; res = {32'h0, t[31:0]};
                     ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         5'd5: begin s = sa - sb; t = s; res = {32'h0, t[31:0]};
                     ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         5'd6: begin s = sa * sb; res = s; lat = 33; end
         5'd7: begin
            if (b == 0) begin res = {a, 32'hFFFFFFFF}; dbz = 1; end
            else begin
               s = sa / sb; t = s; res[31:0] = t[31:0];
               s = sa % sb; t = s; res[63:32] = t[31:0];
               lat = 33;
            end
         end
         5'd8:  res = {32'h0, a >> amt};
         5'd9:  begin s = sa >>> amt; t = s; res = {32'h0, t[31:0]}; end
         5'd10: res = {32'h0, a << amt};
         5'd11: begin r = a; for (int i = 0; i < amt; i++) r = {r[0], r[31:1]}; res = {32'h0, r}; end
         5'd12: begin r = a; for (int i = 0; i < amt; i++) r = {r[30:0], r[31]}; res = {32'h0, r}; end
         default: ill = 1;
      endcase
   endfunction

   // Launch one op, scramble the inputs after acceptance, wait (bounded) for done
   task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output logic ovf, output logic dbz,
                        output logic ill, output int lat, output int busy_n, output logic both,
                        output logic [63:0] res_after, output logic done_after);
      @(negedge clk);
      bus.start = 1'b1; bus.opcode = op; bus.input_a = a; bus.input_b = b;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.opcode = 5'($urandom); bus.input_a = $urandom; bus.input_b = $urandom;
      lat = 0; busy_n = 0; both = 0; res = 'x; ovf = 'x; dbz = 'x; ill = 'x;
      for (int k = 1; k <= 100; k++) begin
         if (bus.busy) busy_n++;
         if (bus.busy && bus.done) both = 1;
         if (bus.done) begin
            lat = k; res = bus.result; ovf = bus.overflow; dbz = bus.div_by_zero; ill = bus.illegal_op;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      res_after = bus.result; done_after = bus.done;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.start = 1'b0; bus.opcode = '0; bus.input_a = '0; bus.input_b = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.overflow, bus.div_by_zero, bus.illegal_op} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b required 00000",
            {bus.busy, bus.done, bus.overflow, bus.div_by_zero, bus.illegal_op});
      end
      checks++;
      if (bus.result !== 64'h0) begin
         errors++; $display("FAIL reset_result: got %h required 0", bus.result);
      end
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({bus.busy, bus.done} !== 2'b00) begin
         errors++; $display("FAIL post_reset_idle: got busy/done %b required 00", {bus.busy, bus.done});
      end
   endtask

   task automatic test_add();
      logic [63:0] res, ra; logic ovf, dbz, ill, da, both; int lat, bn;
      do_op(OP_ADD, 32'd4, 32'd2, res, ovf, dbz, ill, lat, bn, both, ra, da);
      checks++; if (res !== 64'h6) begin errors++; $display("FAIL add_4_2: got %h required 6", res); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d required 1", lat); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL add_ovf0: got %b required 0", ovf); end
      checks++; if (bn !== 0) begin errors++; $display("FAIL add_busy: got %0d busy cycles required 0", bn); end
      do_op(OP_ADD, 32'h7FFFFFFF, 32'd1, res, ovf, dbz, ill, lat, bn, both, ra, da);
      checks++; if (res !== 64'h80000000) begin errors++; $display("FAIL add_ovf_res: got %h required 80000000", res); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL add_ovf1: got %b required 1", ovf); end
   endtask

   task automatic test_mul();
      logic [63:0] res; int lat, bn; logic both;
      @(negedge clk);
      bus.start = 1'b1; bus.opcode = OP_MUL; bus.input_a = 32'hFFFFFFFD; bus.input_b = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.input_a = $urandom; bus.input_b = $urandom;
      lat = 0; bn = 0; both = 0; res = 'x;
      for (int k = 1; k <= 100; k++) begin
         if (bus.busy) bn++;
         if (bus.busy && bus.done) both = 1;
         if (k == 5) begin bus.start = 1'b1; bus.opcode = OP_ADD; bus.input_a = 1; bus.input_b = 1; end
         if (k == 6) bus.start = 1'b0;
         if (bus.done) begin lat = k; res = bus.result; break; end
         @(posedge clk); #1;
      end
      bus.start = 1'b1; bus.opcode = OP_ADD; bus.input_a = 32'd1; bus.input_b = 32'd1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      checks++; if (res !== 64'hFFFFFFFF_FFFFFFEB) begin errors++; $display("FAIL mul_neg3x7: got %h required ffffffffffffffeb", res); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d required 33", lat); end
      checks++; if (bn !== 32) begin errors++; $display("FAIL mul_busy_cycles: got %0d required 32", bn); end
      checks++; if (both !== 1'b0) begin errors++; $display("FAIL mul_busy_done_overlap: got %b required 0", both); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mul_fin_start_ignored: got done %b required 0", bus.done); end
      checks++; if (bus.result !== 64'hFFFFFFFF_FFFFFFEB) begin errors++; $display("FAIL mul_hold: got %h required ffffffffffffffeb", bus.result); end
      @(posedge clk); #1;
   endtask

   task automatic test_div();
      logic [63:0] res, ra; logic ovf, dbz, ill, da, both; int lat, bn;
      do_op(OP_DIV, 32'hFFFFFFF9, 32'd2, res, ovf, dbz, ill, lat, bn, both, ra, da);
      checks++; if (res !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_m7_2: got %h required fffffffffffffffd", res); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d required 33", lat); end
      do_op(OP_DIV, 32'd5, 32'd0, res, ovf, dbz, ill, lat, bn, both, ra, da);
      checks++; if (res !== 64'h00000005_FFFFFFFF) begin errors++; $display("FAIL div_by0_res: got %h required 00000005ffffffff", res); end
      checks++; if (dbz !== 1'b1) begin errors++; $display("FAIL div_by0_flag: got %b required 1", dbz); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL div_by0_latency: got %0d required 1", lat); end
      do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, res, ovf, dbz, ill, lat, bn, both, ra, da);
      checks++; if (res !== 64'h00000000_80000000) begin errors++; $display("FAIL div_min_m1: got %h required 0000000080000000", res); end
      checks++; if ({ovf, dbz, ill} !== 3'b000) begin errors++; $display("FAIL div_min_m1_flags: got %b required 000", {ovf, dbz, ill}); end
   endtask

   task automatic test_shifts();
      logic [63:0] res, ra; logic ovf, dbz, ill, da, both; int lat, bn;
      do_op(OP_SHRA, 32'h80000000, 32'd36, res, ovf, dbz, ill, lat, bn, both, ra, da);
      checks++; if (res !== 64'hF8000000) begin errors++; $display("FAIL shra_36: got %h required f8000000", res); end
      do_op(OP_ROR, 32'd1, 32'd1, res, ovf, dbz, ill, lat, bn, both, ra, da);
      checks++; if (res !== 64'h80000000) begin errors++; $display("FAIL ror_1: got %h required 80000000", res); end
      do_op(OP_ROL, 32'h80000000, 32'd1, res, ovf, dbz, ill, lat, bn, both, ra, da);
      checks++; if (res !== 64'h1) begin errors++; $display("FAIL rol_1: got %h required 1", res); end
   endtask

   task automatic test_illegal();
      logic [63:0] res, ra; logic ovf, dbz, ill, da, both; int lat, bn;
      do_op(5'd13, 32'h1234, 32'h5678, res, ovf, dbz, ill, lat, bn, both, ra, da);
      checks++; if (res !== 64'h0) begin errors++; $display("FAIL illegal_res: got %h required 0", res); end
      checks++; if (ill !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b required 1", ill); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL illegal_latency: got %0d required 1", lat); end
      do_op(OP_AND, 32'd4, 32'd2, res, ovf, dbz, ill, lat, bn, both, ra, da);
      checks++; if (res !== 64'h0) begin errors++; $display("FAIL and_4_2: got %h required 0", res); end
      checks++; if (ill !== 1'b0) begin errors++; $display("FAIL and_clears_illegal: got %b required 0", ill); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bus.start = 1'b1; bus.opcode = OP_ADD; bus.input_a = 32'd4; bus.input_b = 32'd2;
      @(posedge clk); #1;
      checks++; if ({bus.done, bus.result} !== {1'b1, 64'h6}) begin
         errors++; $display("FAIL b2b_first: got done %b result %h required 1 6", bus.done, bus.result); end
      bus.opcode = OP_SUB; bus.input_a = 32'd10; bus.input_b = 32'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      checks++; if ({bus.done, bus.result} !== {1'b1, 64'h7}) begin
         errors++; $display("FAIL b2b_second: got done %b result %h required 1 7", bus.done, bus.result); end
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse: got %b required 0", bus.done); end
   endtask

   task automatic test_reset_mid_mul();
      logic [63:0] res, ra; logic ovf, dbz, ill, da, both; int lat, bn;
      do_op(OP_ADD, 32'd4, 32'd2, res, ovf, dbz, ill, lat, bn, both, ra, da);
      @(negedge clk);
      bus.start = 1'b1; bus.opcode = OP_MUL; bus.input_a = 32'd123; bus.input_b = 32'd456;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_mul_busy: got %b required 1", bus.busy); end
      reset_n = 1'b0;
      #1;
      checks++; if ({bus.busy, bus.done, bus.result} !== {2'b00, 64'h0}) begin
         errors++; $display("FAIL async_reset: got busy %b done %b result %h required 0 0 0", bus.busy, bus.done, bus.result); end
      @(negedge clk); reset_n = 1'b1;
      do_op(OP_ADD, 32'd4, 32'd2, res, ovf, dbz, ill, lat, bn, both, ra, da);
      checks++; if (res !== 64'h6) begin errors++; $display("FAIL post_reset_add: got %h required 6", res); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL post_reset_latency: got %0d required 1", lat); end
   endtask

   task automatic test_random();
      logic [63:0] res, ra, eres; logic ovf, dbz, ill, da, both, eovf, edbz, eill;
      int lat, bn, elat;
      logic [4:0] op; logic [31:0] a, b;
      for (int n = 0; n < 60; n++) begin
         op = 5'($urandom_range(0, 14));
         a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
         model(op, a, b, eres, eovf, edbz, eill, elat);
         do_op(op, a, b, res, ovf, dbz, ill, lat, bn, both, ra, da);
         checks++; if (res !== eres) begin errors++;
            $display("FAIL rand_result op=%0d a=%h b=%h: got %h required %h", op, a, b, res, eres); end
         checks++; if ({ovf, dbz, ill} !== {eovf, edbz, eill}) begin errors++;
            $display("FAIL rand_flags op=%0d a=%h b=%h: got %b required %b", op, a, b, {ovf, dbz, ill}, {eovf, edbz, eill}); end
         checks++; if (lat !== elat) begin errors++;
            $display("FAIL rand_latency op=%0d: got %0d required %0d", op, lat, elat); end
         checks++; if (bn !== elat - 1) begin errors++;
            $display("FAIL rand_busy op=%0d: got %0d required %0d", op, bn, elat - 1); end
         checks++; if ({both, da, ra} !== {2'b00, eres}) begin errors++;
            $display("FAIL rand_hold op=%0d: got overlap %b done %b result %h required 0 0 %h", op, both, da, ra, eres); end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_mul();
      test_div();
      test_shifts();
      test_illegal();
      test_back_to_back();
      test_reset_mid_mul();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle, parametrised-width ALU for the CPU datapath, superseding the single-cycle combinational ALU. The ALU keeps the same 5-bit opcode map and the same 2×WIDTH result (HI:LO). It adds a start/busy/done handshake, an iterative radix-2 Booth multiplier, a non-restoring signed divider, and status flags. It sits between the A/B operand registers and the Z (HI:LO) register and is sequenced by the control unit.

## Interface
- WIDTH, 32, operand width. Must be a power of two, ≥ 8.
- SHW, $clog2(WIDTH), shift-amount width. Derived; not overridable.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  launch request; sampled only in IDLE.
- opcode  in  5  operation: 0 AND, 1 OR, 2 NOT, 3 NEG, 4 ADD, 5 SUB, 6 MUL, 7 DIV, 8 SHR, 9 SHRA, 10 SHL, 11 ROR, 12 ROL; 13–31 illegal.
- input_a  in  WIDTH  operand A (dividend, shift source).
- input_b  in  WIDTH  operand B (divisor, shift amount = input_b[SHW-1:0]).
- busy  out  1  iteration in progress.
- done  out  1  one-cycle pulse; result and flags valid.
- result  out  2·WIDTH  {HI, LO}; held until the next done.
- overflow  out  1  signed overflow for ADD, SUB and NEG.
- div_by_zero  out  1  DIV with input_b == 0.
- illegal_op  out  1  opcode ≥ 13.

## Operation
- States: IDLE, MUL_IT, DIV_IT, FIN.
- Operands and opcode are captured on the accepting edge. They may change afterwards without affecting the operation.
- IDLE with start=1 and a non-iterative opcode:
  - the result is registered at that edge;
  - done=1 in the next cycle;
  - the state stays IDLE.
- Non-iterative results: LO = operation result, HI = 0.
- IDLE with start=1 and MUL: go to MUL_IT.
  - One Booth step per cycle, WIDTH steps.
  - Then FIN. FIN asserts done for one cycle and returns to IDLE.
- MUL result: full signed product, 2·WIDTH bits.
- IDLE with start=1 and DIV, input_b ≠ 0: go to DIV_IT.
  - WIDTH non-restoring steps on the magnitudes.
  - One sign fix-up in FIN.
- DIV result: HI = remainder (takes the sign of the dividend), LO = quotient (truncated toward zero).
- DIV with input_b == 0: no iteration.
  - LO = all ones, HI = input_a, div_by_zero=1.
  - Handled as a non-iterative op.
- Special case: DIV of the most negative value by −1 gives LO = the most negative value, HI = 0, no flag.
- Shifts: the amount is input_b mod WIDTH. SHRA sign-fills; ROR and ROL rotate.
- overflow is valid only for ADD, SUB and NEG; it is 0 otherwise.
- All flags update only with done and hold until the next done.
- start during busy or FIN is ignored; it is neither queued nor errored.
- Illegal opcode: result 0, illegal_op=1, done in the next cycle.

## Timing
- Let cycle 0 be the accepting edge.
- Non-iterative ops: done in cycle 1; busy is never asserted.
- MUL and non-zero DIV:
  - busy=1 in cycles 1..WIDTH;
  - FIN in cycle WIDTH+1, with done=1 and busy=0;
  - a new start is accepted in cycle WIDTH+2 at the earliest.
- Non-iterative ops: a new start may be accepted in cycle 1, back-to-back with done.
- Reset values: state IDLE; busy, done, result, overflow, div_by_zero and illegal_op all 0.
- reset_n low mid-iteration forces reset values immediately (asynchronously). The partial result is discarded.
- done and busy are never high together.

## Structure
- Package alu_pkg holds:
  - opcode localparams (OP_AND … OP_ROL);
  - the state enum type;
  - the NUM_OPS constant.
- Sub-module seq_alu_iter holds the shared shift-register datapath: accumulator, Q register, step counter of width SHW+1, and the Booth/non-restoring step logic.
  - It is selected by mode, started by load, and reports last_step.
- The top level holds the FSM, the combinational single-cycle ops, the result/flag registers and the DIV sign fix-up.

## Test plan
- ADD, WIDTH=32, a=4, b=2 → result 0x00000000_00000006, done in cycle 1, overflow=0. ADD a=0x7FFFFFFF, b=1 → LO=0x80000000, overflow=1.
- MUL a=0xFFFFFFFD (−3), b=7:
  - → result 0xFFFFFFFF_FFFFFFEB;
  - busy in cycles 1–32, done in cycle 33;
  - start pulses in cycles 5 and 33 are ignored.
- DIV a=−7, b=2 → HI=0xFFFFFFFF (−1), LO=0xFFFFFFFD (−3), done in cycle 33. DIV a=5, b=0 → result 0x00000005_FFFFFFFF, div_by_zero=1, done in cycle 1.
- Shifts:
  - SHRA a=0x80000000, b=36 → LO=0xF8000000 (amount 4);
  - ROR a=1, b=1 → LO=0x80000000;
  - ROL a=0x80000000, b=1 → LO=1.
- Reset during MUL: reset_n low in cycle 10 → busy, done and result go to 0 immediately. After release, ADD 4+2 → 6 with done one cycle after start.
- Opcode 13 → result 0, illegal_op=1, done in cycle 1. A following AND 4&2 → 0 with illegal_op=0.
